// File: rtl/nibble_pkg.sv
// Shared types and constants for the Nibble CPU sequencer and its bench.
package nibble_pkg;

    localparam int unsigned PC_W   = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic [OP_W-1:0] {
        NOP  = 3'b000,
        ADD  = 3'b001,
        SUB  = 3'b010,
        MOVX = 3'b011,
        JMP  = 3'b100,
        JOV  = 3'b101,
        CLRF = 3'b110,
        HLT  = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD_IR = 3'd2,
        DECODE  = 3'd3,
        EXECUTE = 3'd4,
        STORE   = 3'd5,
        HALT    = 3'd6
    } state_t;

    // Ops that route y through the adder and may raise overflow.
    function automatic logic is_arith(op_t op);
        return (op == ADD) || (op == SUB);
    endfunction

    function automatic logic writes_ram(op_t op);
        return (op == ADD) || (op == SUB) || (op == MOVX);
    endfunction

endpackage

// File: rtl/nibble_pc.sv
// Program counter register: load has priority over increment, otherwise hold.
module nibble_pc #(
    parameter int unsigned     PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/nibble_control.sv
// Five-phase instruction sequencer for the Nibble datapath: owns PC and the
// sticky overflow flag, and decodes datapath enables from state and opcode.
module nibble_control
    import nibble_pkg::*;
#(
    parameter int unsigned     PC_W     = nibble_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              ovf_in,
    output logic [PC_W-1:0]   pc,
    output logic              ir_en,
    output logic              dec_en,
    output logic              sub_sel,
    output logic              y_sel,
    output logic              ram_we,
    output logic              ovf_flag,
    output logic              busy,
    output logic              halted
);

    state_t state_q;
    state_t state_d;
    logic   ovf_flag_q;
    logic   ovf_flag_d;
    logic   pc_inc;
    logic   pc_load;
    op_t    op;
    logic   exec_phase;

    assign op = op_t'(op_in);

    nibble_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock    (clock),
        .reset    (reset),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (PC_W'(addr_in)),
        .pc       (pc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            ovf_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    // Next state, flag update and PC control.
    always_comb begin
        state_d    = state_q;
        ovf_flag_d = ovf_flag_q;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = LOAD_IR;
            LOAD_IR: state_d = DECODE;
            DECODE:  state_d = EXECUTE;
            EXECUTE: begin
                state_d = STORE;
                if (is_arith(op) && ovf_in) ovf_flag_d = 1'b1;
            end
            STORE: begin
                state_d = FETCH;
                case (op)
                    JMP:     pc_load = 1'b1;
                    JOV: begin
                        pc_load = ovf_flag_q;
                        pc_inc  = !ovf_flag_q;
                    end
                    CLRF: begin
                        ovf_flag_d = 1'b0;
                        pc_inc     = 1'b1;
                    end
                    HLT:     state_d = HALT;
                    default: pc_inc = 1'b1;
                endcase
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls decoded from the current phase and latched opcode.
    always_comb begin
        exec_phase = (state_q == EXECUTE) || (state_q == STORE);
        ir_en      = (state_q == LOAD_IR);
        dec_en     = (state_q == DECODE);
        sub_sel    = exec_phase && (op == SUB);
        y_sel      = exec_phase && is_arith(op);
        // Gating by reset keeps an interrupted STORE from committing its write.
        ram_we     = (state_q == STORE) && writes_ram(op) && reset;
        ovf_flag   = ovf_flag_q;
        busy       = (state_q != IDLE) && (state_q != HALT);
        halted     = (state_q == HALT);
    end

endmodule

// File: tb/tb_nibble_control.sv
// Randomized bench: a behavioural datapath drives the sequencer, and an
// instruction-level model predicts every cycle's outputs and final RAM.
module tb_nibble_control;
    import nibble_pkg::*;

    typedef struct packed {
        op_t               op;
        logic [3:0]        addr;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
    } instr_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op_in;
    logic [3:0] addr_in;
    logic       ovf_in;
    logic [3:0] pc;
    logic       ir_en, dec_en, sub_sel, y_sel, ram_we, ovf_flag, busy, halted;

    nibble_control #(.PC_W(4), .RESET_PC(4'h0)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op_in    (op_in),
        .addr_in  (addr_in),
        .ovf_in   (ovf_in),
        .pc       (pc),
        .ir_en    (ir_en),
        .dec_en   (dec_en),
        .sub_sel  (sub_sel),
        .y_sel    (y_sel),
        .ram_we   (ram_we),
        .ovf_flag (ovf_flag),
        .busy     (busy),
        .halted   (halted)
    );

    always #5 clock = ~clock;

    // Datapath: ROM with 1-cycle latency, IR, decode regs, complement/adder, RAM.
    instr_t            rom [16];
    instr_t            rom_q, ir;
    logic [DATA_W-1:0] x_q, y_q, b_mux, sum;
    logic [DATA_W-1:0] ram [16];
    logic              ram_clr = 1'b0;
    logic              junk = 1'b0;
    logic              dp_ovf;

    always_comb begin
        b_mux  = sub_sel ? ~y_q : y_q;
        if (!y_sel) b_mux = '0;
        sum    = x_q + b_mux + DATA_W'(sub_sel);
        dp_ovf = (x_q[DATA_W-1] == b_mux[DATA_W-1]) && (sum[DATA_W-1] != x_q[DATA_W-1]);
    end

    // Non-arithmetic ops present random noise on ovf_in; it must be ignored.
    assign ovf_in = is_arith(op_t'(op_in)) ? dp_ovf : junk;

    always @(posedge clock) begin
        rom_q <= rom[pc];
        if (ir_en) ir <= rom_q;
        if (dec_en) begin
            op_in   <= ir.op;
            addr_in <= ir.addr;
            x_q     <= ir.x;
            y_q     <= ir.y;
        end
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else if (ram_we) begin
            ram[addr_in] <= sum;
        end
    end

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [3:0]        m_pc;
    logic              m_flag;
    logic              m_halt;
    logic [DATA_W-1:0] m_ram [16];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vec(input logic [3:0] p, input logic i, d, s, ys, w, f, b, h);
        return 32'({p, i, d, s, ys, w, f, b, h});
    endfunction

    function automatic logic [31:0] outs();
        return vec(pc, ir_en, dec_en, sub_sel, y_sel, ram_we, ovf_flag, busy, halted);
    endfunction

    function automatic instr_t mk(input op_t op, input logic [3:0] a,
                                  input logic [7:0] x, input logic [7:0] y);
        return {op, a, x, y};
    endfunction

    task automatic step();
        junk = 1'($urandom);
        @(posedge clock);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = mk(NOP, 4'h0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        start   = 1'b0;
        ram_clr = 1'b1;
        step();
        step();
        check_eq("reset_outs", outs(), vec(4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset   = 1'b1;
        ram_clr = 1'b0;
        step();
        check_eq("idle_outs", outs(), vec(4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        m_pc   = 4'h0;
        m_flag = 1'b0;
        m_halt = 1'b0;
        for (int i = 0; i < 16; i++) m_ram[i] = '0;
    endtask

    task automatic run_prog(input string name, input int max_instr);
        instr_t            in;
        logic              ar, we, ovf, flag_x;
        int                s;
        logic [DATA_W-1:0] res;
        start = 1'b1;
        step();
        for (int n = 0; n < max_instr && !m_halt; n++) begin
            in  = rom[m_pc];
            ar  = (in.op == ADD) || (in.op == SUB);
            we  = ar || (in.op == MOVX);
            s   = (in.op == SUB) ? int'($signed(in.x)) - int'($signed(in.y))
                                 : int'($signed(in.x)) + int'($signed(in.y));
            ovf = ar && (s > 127 || s < -128);
            res = (in.op == MOVX) ? in.x : DATA_W'(s);
            flag_x = m_flag | ovf;
            for (int ph = 0; ph < 5; ph++) begin
                check_eq($sformatf("%s_i%0d_ph%0d", name, n, ph), outs(),
                         vec(m_pc, ph == 1, ph == 2, ph >= 3 && in.op == SUB, ph >= 3 && ar,
                             ph == 4 && we, (ph == 4) ? flag_x : m_flag, 1'b1, 1'b0));
                start = 1'($urandom);
                step();
            end
            if (we) m_ram[in.addr] = res;
            case (in.op)
                JMP:     m_pc = in.addr;
                JOV:     m_pc = flag_x ? in.addr : m_pc + 4'd1;
                CLRF:    begin flag_x = 1'b0; m_pc = m_pc + 4'd1; end
                HLT:     m_halt = 1'b1;
                default: m_pc = m_pc + 4'd1;
            endcase
            m_flag = flag_x;
        end
        if (m_halt) begin
            for (int c = 0; c < 20; c++) begin
                check_eq($sformatf("%s_halt%0d", name, c), outs(),
                         vec(m_pc, 0, 0, 0, 0, 0, m_flag, 1'b0, 1'b1));
                start = 1'($urandom);
                step();
            end
        end
        start = 1'b0;
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("%s_ram%0d", name, i), 32'(ram[i]), 32'(m_ram[i]));
    endtask

    initial begin
        instr_t r;
        // Arithmetic, overflow, taken/untaken JOV, CLRF, JMP and PC wrap.
        clear_rom();
        rom[0]  = mk(ADD,  4'h2, 8'h03, 8'h04);
        rom[1]  = mk(SUB,  4'h3, 8'h05, 8'h09);
        rom[2]  = mk(ADD,  4'h4, 8'h7F, 8'h01);
        rom[3]  = mk(JOV,  4'hA, 8'h00, 8'h00);
        rom[10] = mk(CLRF, 4'h0, 8'h00, 8'h00);
        rom[11] = mk(JOV,  4'h0, 8'h00, 8'h00);
        rom[12] = mk(JMP,  4'hF, 8'h00, 8'h00);
        rom[15] = mk(JOV,  4'h5, 8'h00, 8'h00);
        do_reset();
        run_prog("dir", 9);

        // Halt at address 6 holds PC despite start pulses, then reset recovers.
        clear_rom();
        rom[0] = mk(JMP, 4'h6, 8'h00, 8'h00);
        rom[6] = mk(HLT, 4'h0, 8'h00, 8'h00);
        do_reset();
        run_prog("hlt", 10);
        check_eq("hlt_pc", 32'(pc), 32'(4'h6));
        do_reset();

        // Reset landing in STORE must suppress the pending write.
        clear_rom();
        rom[0] = mk(ADD, 4'h5, 8'h01, 8'h01);
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check_eq("rst_store_we", 32'(ram_we), 32'd1);
        reset = 1'b0;
        step();
        check_eq("rst_store_outs", outs(), vec(4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        step();
        check_eq("rst_store_ram", 32'(ram[5]), 32'd0);

        // Random programs with occasional halts and overflow-prone operands.
        for (int p = 0; p < 30; p++) begin
            for (int i = 0; i < 16; i++) begin
                r.op   = op_t'(3'($urandom_range(0, 7)));
                if (r.op == HLT && $urandom_range(0, 3) != 0) r.op = ADD;
                r.addr = 4'($urandom);
                r.x    = ($urandom_range(0, 3) == 0) ? 8'h7F : 8'($urandom);
                r.y    = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
                rom[i] = r;
            end
            do_reset();
            run_prog($sformatf("rnd%0d", p), 25);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
